arm_mc_ctrl: RTL and testbench
==============================

Name: arm_mc_ctrl

Overview:
Multicycle control unit for the ARM-subset core. It sequences fetch, decode, execute and writeback over the shared ALU, memory port and register file. It selects the extender mode via ImmSrc and owns the NZCV flags register and condition-code evaluation. It sits beside the datapath and drives all mux selects and write enables, one instruction at a time.

Parameters:
RESET_FLAGS, 4'b0000, value loaded into NZCV flag register on reset

Ports:
clk  in  1  core clock, rising-edge
reset  in  1  asynchronous, active-high reset
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20] (I, cmd[3:0], S)
Rd  in  4  Instr[15:12]
ALUFlags  in  4  NZCV from ALU, current cycle
PCWrite  out  1  PC register enable
MemWrite  out  1  data memory write enable
RegWrite  out  1  register file write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  1  0=RD1, 1=PC
ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=const 4
ImmSrc  out  2  extender mode: 00 8-bit DP imm, 01 12-bit mem offset, 10 24-bit branch (<<2)
RegSrc  out  2  [0]=1 read PC (branch), [1]=1 read Rd as RA2 (store)
ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr

Behaviour:
- State register, 4 bits, async reset to FETCH. States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions: FETCH->DECODE. DECODE: Op=01->MEMADR; Op=00 & Funct[5]=0->EXECR; Op=00 & Funct[5]=1->EXECI; Op=10->BRANCH; Op=11 (illegal)->FETCH with no side effects. MEMADR: Funct[0]=1 (LDR)->MEMRD, else MEMWR. MEMRD->MEMWB. EXECR/EXECI->ALUWB. MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
- Instruction latencies: LDR 5 cycles, STR 4, DP 4, B 3, illegal 2.
- Per-state controls; unlisted outputs are 0.
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode. ALUOp=0: ALUControl=00.
- ALUOp=1, cmd=Funct[4:1]:
  - 0100 ADD->00; 0010 SUB->01; 0000 AND->10; 1100 ORR->11.
  - 1010 CMP->01 with NoWrite=1.
  - other cmd->00.
  - FlagW[1] (NZ)=Funct[0]; FlagW[0] (CV)=Funct[0] & cmd in {ADD,SUB,CMP}. FlagW=00 when ALUOp=0.
- ImmSrc=Op and RegSrc are pure combinational from Op, valid in every state.
- Condition check: CondEx is combinational from Cond and the registered flags. Codes 0000-1101 follow standard ARM EQ..LE; 1110 AL=1; 1111=0.
- cond_ex_q: registers CondEx every cycle; async reset 0.
- Flag register: NZ loads ALUFlags[3:2] when FlagW[1]&CondEx; CV loads ALUFlags[1:0] when FlagW[0]&CondEx. Update occurs at the end of EXECR/EXECI only.
- Gated enables:
  - RegWrite=RegW & cond_ex_q & ~NoWrite.
  - MemWrite=MemW & cond_ex_q.
  - PCS=(RegW & Rd==15) | Branch.
  - PCWrite=NextPC | (PCS & cond_ex_q).
  - Writeback uses pre-update condition: a failed S-instruction neither writes flags nor Rd.
- Reset: while reset=1, PCWrite/MemWrite/RegWrite/IRWrite forced 0, state=FETCH, flags=RESET_FLAGS. The first FETCH occurs on the first rising edge after deassertion. Reset mid-instruction abandons it with no partial write.

Decomposition:
- Package arm_ctrl_pkg: state encoding constants, ResultSrc/ALUSrcB/ImmSrc encodings, cmd opcodes, condition code constants.
- One sub-module arm_cond_unit: flags register, CondEx evaluation, cond_ex_q.
- FSM and ALU decode live in the top.

Test Plan:
- Reset then release, hold Instr=0xE2811005 (ADD R1,R1,#5): states FETCH,DECODE,EXECI,ALUWB. IRWrite=1 and PCWrite=1 in cycle 0; ImmSrc=00, ALUSrcB=01, ALUControl=00 in EXECI; RegWrite=1 in ALUWB only.
- LDR 0xE5912004: MEMADR->MEMRD->MEMWB, ImmSrc=01, AdrSrc=1 in MEMRD, RegWrite=1 only in MEMWB. STR 0xE5812004: MemWrite=1 in MEMWR, RegSrc=10.
- SUBS 0xE0510002 with ALUFlags=0100 in EXECR: flags become Z=1. Then BEQ 0x0A000003: PCWrite=1 in BRANCH, ImmSrc=10, RegSrc=01. BNE 0x1A000003: PCWrite=0 in BRANCH.
- CMP 0xE1510002: RegWrite=0 in ALUWB, flags updated. ADDNE with Z=1: no RegWrite, no flag write.
- Illegal Op=11: FETCH->DECODE->FETCH, no write enables asserted. Assert reset in MEMWR cycle: MemWrite drops to 0 immediately, state returns to FETCH.
- ADD with Rd=15 (0xE08FF001): PCWrite=1 in ALUWB as well as FETCH.

Source files
------------

// File: rtl/arm_mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// datapath mux encodings, data-processing opcodes and condition evaluation.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Even codes test a base predicate, odd codes its complement (ARM pairing).
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, base;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond == COND_NV)
            return 1'b0;
        else if (cond == COND_AL)
            return 1'b1;
        else
            return base ^ cond[0];
    endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flag register plus condition evaluation; cond_ex_q_o carries the
// previous cycle's verdict so writebacks see the pre-update condition.
import arm_ctrl_pkg::*;

module arm_cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_w_i,
    output logic       cond_ex_q_o
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex;
    logic       cond_ex_q;

    assign cond_ex     = cond_holds(cond_i, flags_q);
    assign cond_ex_q_o = cond_ex_q;

    always_comb begin
        flags_d = flags_q;
        if (flag_w_i[1] && cond_ex)
            flags_d[3:2] = alu_flags_i[3:2];
        if (flag_w_i[0] && cond_ex)
            flags_d[1:0] = alu_flags_i[1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q   <= RESET_FLAGS;
            cond_ex_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex;
        end
    end

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multicycle control FSM and ALU decoder for the ARM-subset core; drives all
// datapath selects and gates write enables with the registered condition.
import arm_ctrl_pkg::*;

module arm_mc_ctrl #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    state_e     state_q, state_d;
    logic       ir_write, next_pc, reg_w, mem_w, alu_op, branch;
    logic       no_write, pcs, cond_ex_q;
    logic [1:0] flag_w;
    logic [3:0] cmd;

    assign cmd = Funct[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ir_write  = 1'b0;
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        alu_op    = 1'b0;
        branch    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = 1'b1;
                next_pc   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: ALUSrcB = SRCB_EXTIMM;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR: alu_op = 1'b1;
            S_EXECI: begin
                ALUSrcB = SRCB_EXTIMM;
                alu_op  = 1'b1;
            end
            S_ALUWB: reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ALUControl = ALU_ADD;
        flag_w     = 2'b00;
        if (alu_op) begin
            case (cmd)
                CMD_ADD: ALUControl = ALU_ADD;
                CMD_SUB: ALUControl = ALU_SUB;
                CMD_AND: ALUControl = ALU_AND;
                CMD_ORR: ALUControl = ALU_ORR;
                CMD_CMP: ALUControl = ALU_SUB;
                default: ALUControl = ALU_ADD;
            endcase
            flag_w[1] = Funct[0];
            flag_w[0] = Funct[0] & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
        end
    end

    // The instruction stays in IR through ALUWB, so CMP is recognised from the fields directly.
    assign no_write = (Op == OP_DP) & (cmd == CMD_CMP);

    assign ImmSrc = Op;
    assign RegSrc = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BR)};

    assign pcs      = (reg_w & (Rd == 4'd15)) | branch;
    assign PCWrite  = ~reset & (next_pc | (pcs & cond_ex_q));
    assign MemWrite = ~reset & mem_w & cond_ex_q;
    assign RegWrite = ~reset & reg_w & cond_ex_q & ~no_write;
    assign IRWrite  = ~reset & ir_write;

    arm_cond_unit #(
        .RESET_FLAGS(RESET_FLAGS)
    ) u_cond (
        .clk        (clk),
        .rst        (reset),
        .cond_i     (Cond),
        .alu_flags_i(ALUFlags),
        .flag_w_i   (flag_w),
        .cond_ex_q_o(cond_ex_q)
    );

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// Self-checking bench for arm_mc_ctrl: directed instruction table, reset
// corner cases and random instructions against a per-cycle reference model.
module tb_arm_mc_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a;
    logic [1:0] result_src, alu_src_b, imm_src, reg_src, alu_control;

    int         n_vec;
    int         n_err;
    logic [3:0] m_flags;

    arm_mc_ctrl #(.RESET_FLAGS(4'b0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (cond),
        .Op        (op),
        .Funct     (funct),
        .Rd        (rd),
        .ALUFlags  (alu_flags),
        .PCWrite   (pc_write),
        .MemWrite  (mem_write),
        .RegWrite  (reg_write),
        .IRWrite   (ir_write),
        .AdrSrc    (adr_src),
        .ResultSrc (result_src),
        .ALUSrcA   (alu_src_a),
        .ALUSrcB   (alu_src_b),
        .ImmSrc    (imm_src),
        .RegSrc    (reg_src),
        .ALUControl(alu_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  aluf;
        logic        last_pcw;
        logic        last_regw;
        logic        last_memw;
    } vec_t;

    function automatic logic [15:0] actual_out();
        return {pc_write, mem_write, reg_write, ir_write, adr_src, result_src,
                alu_src_a, alu_src_b, imm_src, reg_src, alu_control};
    endfunction

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int inst_len(input logic [31:0] ins);
        case (ins[27:26])
            2'b01:   return ins[20] ? 5 : 4;
            2'b00:   return 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    // Expected outputs for cycle cyc of an instruction, counted from its fetch.
    function automatic logic [15:0] model_out(input logic [31:0] ins, input int cyc, input logic pass);
        logic [1:0] o_op, res, srcb, imm, rsrc, ctl;
        logic [3:0] o_cmd;
        logic       load, rd15, pcw, memw, regw, irw, adr, srca;
        o_op = ins[27:26];
        o_cmd = ins[24:21];
        load = ins[20];
        rd15 = (ins[15:12] == 4'd15);
        pcw = 0; memw = 0; regw = 0; irw = 0; adr = 0; srca = 0;
        res = 0; srcb = 0; ctl = 0;
        imm = o_op;
        rsrc = {(o_op == 2'b01) && !load, o_op == 2'b10};
        if (cyc == 0) begin
            pcw = 1; irw = 1; srca = 1; srcb = 2; res = 2;
        end else if (cyc == 1) begin
            srca = 1; srcb = 2; res = 2;
        end else begin
            case (o_op)
                2'b01: begin
                    if (cyc == 2) srcb = 1;
                    else if (cyc == 3) begin
                        adr = 1;
                        if (!load) memw = pass;
                    end else begin
                        res = 1; regw = pass; pcw = rd15 && pass;
                    end
                end
                2'b00: begin
                    if (cyc == 2) begin
                        srcb = ins[25] ? 2'd1 : 2'd0;
                        case (o_cmd)
                            4'd2, 4'd10: ctl = 1;
                            4'd0:        ctl = 2;
                            4'd12:       ctl = 3;
                            default:     ctl = 0;
                        endcase
                    end else begin
                        res = 0; regw = pass && (o_cmd != 4'd10); pcw = rd15 && pass;
                    end
                end
                2'b10: begin
                    srcb = 1; res = 2; pcw = pass;
                end
                default: ;
            endcase
        end
        return {pcw, memw, regw, irw, adr, res, srca, srcb, imm, rsrc, ctl};
    endfunction

    // Entered just after a rising edge with the DUT in FETCH; leaves it the same way.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] aluf, output logic [15:0] last_act);
        logic [15:0] exp_v, act_v;
        logic        pass;
        int          len;
        logic [3:0]  c;
        cond = ins[31:28]; op = ins[27:26]; funct = ins[25:20]; rd = ins[15:12];
        alu_flags = aluf;
        pass = cond_pass(ins[31:28], m_flags);
        len = inst_len(ins);
        last_act = '0;
        for (int cyc = 0; cyc < len; cyc++) begin
            @(negedge clk);
            exp_v = model_out(ins, cyc, pass);
            act_v = actual_out();
            n_vec++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL ctrl instr=%08h cyc=%0d got=%04h want=%04h", ins, cyc, act_v, exp_v);
            end else
                $display("ok   instr=%08h cyc=%0d out=%04h", ins, cyc, act_v);
            last_act = act_v;
            @(posedge clk);
            #1;
        end
        c = ins[24:21];
        if (ins[27:26] == 2'b00 && ins[20] && pass) begin
            m_flags[3:2] = aluf[3:2];
            if (c == 4'd4 || c == 4'd2 || c == 4'd10)
                m_flags[1:0] = aluf[1:0];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t        tbl[12];
    logic [15:0] last;
    logic [31:0] rins;
    logic [3:0]  cmds[5];

    initial begin
        n_vec = 0;
        n_err = 0;
        m_flags = 4'b0000;
        tbl[0]  = '{32'hE2811005, 4'h0, 1'b0, 1'b1, 1'b0};  // ADD r1,r1,#5
        tbl[1]  = '{32'hE5912004, 4'h0, 1'b0, 1'b1, 1'b0};  // LDR
        tbl[2]  = '{32'hE5812004, 4'h0, 1'b0, 1'b0, 1'b1};  // STR
        tbl[3]  = '{32'hE0510002, 4'h4, 1'b0, 1'b1, 1'b0};  // SUBS -> Z=1
        tbl[4]  = '{32'h0A000003, 4'h0, 1'b1, 1'b0, 1'b0};  // BEQ taken
        tbl[5]  = '{32'h1A000003, 4'h0, 1'b0, 1'b0, 1'b0};  // BNE not taken
        tbl[6]  = '{32'hE1510002, 4'h4, 1'b0, 1'b0, 1'b0};  // CMP, Z stays 1
        tbl[7]  = '{32'h10911002, 4'h8, 1'b0, 1'b0, 1'b0};  // ADDSNE skipped
        tbl[8]  = '{32'h0A000003, 4'h0, 1'b1, 1'b0, 1'b0};  // BEQ: flags untouched
        tbl[9]  = '{32'hEC000000, 4'h0, 1'b0, 1'b0, 1'b0};  // illegal op
        tbl[10] = '{32'hE08FF001, 4'h0, 1'b1, 1'b1, 1'b0};  // ADD pc,pc,r1
        tbl[11] = '{32'hE0911002, 4'h1, 1'b0, 1'b1, 1'b0};  // ADDS, sets V only
        cmds[0] = 4'd4; cmds[1] = 4'd2; cmds[2] = 4'd0; cmds[3] = 4'd12; cmds[4] = 4'd10;

        reset = 1'b1;
        cond = 4'hE; op = 2'b00; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({pc_write, mem_write, reg_write, ir_write} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_enables got=%b want=0000", {pc_write, mem_write, reg_write, ir_write});
        end else
            $display("ok   reset enables low");
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_instr(tbl[i].instr, tbl[i].aluf, last);
            n_vec++;
            if ({last[15], last[13], last[14]} !== {tbl[i].last_pcw, tbl[i].last_regw, tbl[i].last_memw}) begin
                n_err++;
                $display("FAIL table_last[%0d] got pcw/regw/memw=%b want=%b", i,
                         {last[15], last[13], last[14]},
                         {tbl[i].last_pcw, tbl[i].last_regw, tbl[i].last_memw});
            end else
                $display("ok   table[%0d] last-cycle enables", i);
        end

        // Reset during MEMWR of a store: enables drop at once and the store is abandoned.
        cond = 4'hE; op = 2'b01; funct = 6'b011000; rd = 4'd2; alu_flags = 4'd0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_vec++;
        if (mem_write !== 1'b1) begin
            n_err++;
            $display("FAIL memwr_before_reset got=%b want=1", mem_write);
        end else
            $display("ok   MEMWR MemWrite=1 before reset");
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if ({pc_write, mem_write, reg_write, ir_write} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_midinstr got=%b want=0000", {pc_write, mem_write, reg_write, ir_write});
        end else
            $display("ok   mid-instruction reset forces enables low");
        @(posedge clk);
        #1 reset = 1'b0;
        m_flags = 4'b0000;
        run_instr(32'h0A000003, 4'h0, last);   // BEQ after reset: Z cleared, not taken
        run_instr(32'hE2811005, 4'h0, last);

        // Random instructions checked cycle by cycle against the model.
        for (int k = 0; k < 250; k++) begin
            int cls;
            rins = $urandom;
            cls = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) rins[31:28] = 4'hE;
            if (cls <= 1)      rins[27:26] = 2'b01;
            else if (cls <= 6) begin
                rins[27:26] = 2'b00;
                if ($urandom_range(0, 4) != 0) rins[24:21] = cmds[$urandom_range(0, 4)];
            end
            else if (cls <= 8) rins[27:26] = 2'b10;
            else               rins[27:26] = 2'b11;
            run_instr(rins, 4'($urandom), last);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
